// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file responder and its clear sequencer.
package regfile_pkg;

    localparam int RF_WIDTH  = 32;
    localparam int RF_DEPTH  = 32;
    localparam int RF_ADDR_W = 5;

    // Register 0 always reads as zero and cannot be written.
    localparam int REG_ZERO = 0;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every register address once after reset or on request,
// and reports busy for the duration of the sweep.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH  = RF_DEPTH,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    output logic              o_busy,
    output logic              o_sweep_we,
    output logic [ADDR_W-1:0] o_sweep_addr
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic              r_busy;

    // Sweep FSM; busy is kept as its own register so it is a clean state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
            r_idx   <= {ADDR_W{1'b0}};
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_idx == ADDR_W'(DEPTH - 1)) begin
                        r_state <= ST_READY;
                        r_idx   <= {ADDR_W{1'b0}};
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_CLEAR;
                        r_idx   <= r_idx + ADDR_W'(1);
                        r_busy  <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (i_clear) begin
                        r_state <= ST_CLEAR;
                        r_idx   <= {ADDR_W{1'b0}};
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_READY;
                        r_idx   <= r_idx;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_idx   <= {ADDR_W{1'b0}};
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_sweep_we   = (r_state == ST_CLEAR);
    assign o_sweep_addr = r_idx;

endmodule

// File: rtl/regfile_responder.sv
// Handshaked register-file target: single-cycle writes, two-port reads through a
// one-entry registered response buffer, and a self-clearing array.
module regfile_responder
    import regfile_pkg::*;
#(
    parameter int WIDTH  = RF_WIDTH,
    parameter int DEPTH  = RF_DEPTH,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    output logic              busy,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] Aw,
    input  logic [WIDTH-1:0]  Dw,
    output logic              wr_err,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] Aa,
    input  logic [ADDR_W-1:0] Ab,
    output logic [WIDTH-1:0]  Da,
    output logic [WIDTH-1:0]  Db,
    output logic              rsp_valid,
    input  logic              rsp_ready
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [WIDTH-1:0]  r_da;
    logic [WIDTH-1:0]  r_db;
    logic              r_rsp_valid;
    logic              r_wr_err;

    logic              w_busy;
    logic              w_sweep_we;
    logic [ADDR_W-1:0] w_sweep_addr;
    logic              w_wr_accept;
    logic              w_rd_ready;
    logic              w_capture;
    logic [WIDTH-1:0]  w_rd_a;
    logic [WIDTH-1:0]  w_rd_b;

    regfile_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (clear),
        .o_busy       (w_busy),
        .o_sweep_we   (w_sweep_we),
        .o_sweep_addr (w_sweep_addr)
    );

    // A clear request in the same cycle wins over the write.
    assign w_wr_accept = !w_busy && WrEn && !clear && (Aw != ZERO_ADDR);
    assign w_rd_ready  = !w_busy && (!r_rsp_valid || rsp_ready);
    assign w_capture   = rd_valid && w_rd_ready;

    // Port A read value with write-through bypass.
    always_comb begin
        w_rd_a = {WIDTH{1'b0}};
        if (Aa == ZERO_ADDR) begin
            w_rd_a = {WIDTH{1'b0}};
        end else if (w_wr_accept && (Aw == Aa)) begin
            w_rd_a = Dw;
        end else begin
            w_rd_a = r_mem[Aa];
        end
    end

    // Port B read value with write-through bypass.
    always_comb begin
        w_rd_b = {WIDTH{1'b0}};
        if (Ab == ZERO_ADDR) begin
            w_rd_b = {WIDTH{1'b0}};
        end else if (w_wr_accept && (Aw == Ab)) begin
            w_rd_b = Dw;
        end else begin
            w_rd_b = r_mem[Ab];
        end
    end

    // Array write port shared by the clear sweep and user writes; contents are not reset.
    always_ff @(posedge clk) begin
        if (w_sweep_we) begin
            r_mem[w_sweep_addr] <= {WIDTH{1'b0}};
        end else if (w_wr_accept) begin
            r_mem[Aw] <= Dw;
        end
    end

    // Response buffer and dropped-write flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_da        <= {WIDTH{1'b0}};
            r_db        <= {WIDTH{1'b0}};
            r_rsp_valid <= 1'b0;
            r_wr_err    <= 1'b0;
        end else begin
            r_wr_err <= WrEn && (w_busy || clear);
            if (w_capture) begin
                r_da        <= w_rd_a;
                r_db        <= w_rd_b;
                r_rsp_valid <= 1'b1;
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end else begin
                r_rsp_valid <= r_rsp_valid;
            end
        end
    end

    assign busy      = w_busy;
    assign wr_err    = r_wr_err;
    assign rd_ready  = w_rd_ready;
    assign Da        = r_da;
    assign Db        = r_db;
    assign rsp_valid = r_rsp_valid;

endmodule

// File: tb/tb_regfile_responder.sv
// Self-checking bench for regfile_responder: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_regfile_responder;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          clear = 1'b0;
    logic          WrEn = 1'b0;
    logic [AW-1:0] Aw = '0;
    logic [W-1:0]  Dw = '0;
    logic          rd_valid = 1'b0;
    logic [AW-1:0] Aa = '0;
    logic [AW-1:0] Ab = '0;
    logic          rsp_ready = 1'b1;
    logic          busy, wr_err, rd_ready, rsp_valid;
    logic [W-1:0]  Da, Db;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [W-1:0] m_mem [D];
    int           m_clear_left;
    bit           m_rsp_valid;
    logic [W-1:0] m_da, m_db;
    bit           m_wr_err;
    logic         obs_rd_ready;
    bit           exp_rd_ready;

    regfile_responder dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy),
        .WrEn(WrEn), .Aw(Aw), .Dw(Dw), .wr_err(wr_err),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .Aa(Aa), .Ab(Ab),
        .Da(Da), .Db(Db), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_clear_left = D;
        m_rsp_valid  = 1'b0;
        m_da         = '0;
        m_db         = '0;
        m_wr_err     = 1'b0;
        for (int i = 0; i < D; i++) m_mem[i] = '0;
    endtask

    function automatic bit m_rd_ready();
        return (m_clear_left == 0) && (!m_rsp_valid || rsp_ready);
    endfunction

    function automatic logic [W-1:0] m_read(input logic [AW-1:0] a, input bit wr_acc);
        if (a == 0) return '0;
        if (wr_acc && Aw == a) return Dw;
        return m_mem[a];
    endfunction

    task automatic model_edge();
        bit ready, acc, cap;
        ready = (m_clear_left == 0);
        acc   = ready && WrEn && !clear && (Aw != 0);
        cap   = rd_valid && m_rd_ready();
        m_wr_err = WrEn && (!ready || clear);
        if (cap) begin
            m_da = m_read(Aa, acc);
            m_db = m_read(Ab, acc);
            m_rsp_valid = 1'b1;
        end else if (rsp_ready) begin
            m_rsp_valid = 1'b0;
        end
        if (acc) m_mem[Aw] = Dw;
        if (!ready) begin
            m_clear_left--;
        end else if (clear) begin
            m_clear_left = D;
            for (int i = 0; i < D; i++) m_mem[i] = '0;
        end
    endtask

    // One clock: sample rd_ready before the edge, advance the model, land at posedge+1.
    task automatic cycle();
        @(negedge clk);
        obs_rd_ready = rd_ready;
        exp_rd_ready = m_rd_ready();
        if (rst_n) model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int  n;
        bit  rdy_seen;
        #1 rst_n = 1'b0;
        model_reset();
        repeat (3) cycle();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (Da !== 32'd0 || Db !== 32'd0) begin errors++; $display("FAIL reset_data: got %0d/%0d expected 0/0", Da, Db); end
        checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err: got %b expected 0", wr_err); end
        rst_n = 1'b1;
        n = 0; rdy_seen = 1'b0;
        for (int i = 0; i < 40 && busy === 1'b1; i++) begin
            n++;
            cycle();
            if (obs_rd_ready !== 1'b0) rdy_seen = 1'b1;
        end
        checks++; if (n != 32) begin errors++; $display("FAIL reset_busy_len: got %0d expected 32", n); end
        checks++; if (rdy_seen) begin errors++; $display("FAIL reset_rd_ready_during_sweep: got 1 expected 0"); end
        rd_valid = 1'b1; Aa = 5'd7; Ab = 5'd31;
        cycle();
        rd_valid = 1'b0;
        checks++; if (obs_rd_ready !== 1'b1) begin errors++; $display("FAIL reset_rd_ready_after: got %b expected 1", obs_rd_ready); end
        checks++; if (rsp_valid !== 1'b1 || Da !== 32'd0 || Db !== 32'd0) begin errors++; $display("FAIL reset_first_read: got v=%b %0d/%0d expected v=1 0/0", rsp_valid, Da, Db); end
    endtask

    task automatic test_write_read();
        WrEn = 1'b1; Aw = 5'd4; Dw = 32'd69;
        cycle();
        WrEn = 1'b0; rd_valid = 1'b1; Aa = 5'd4; Ab = 5'd4;
        cycle();
        rd_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || Da !== 32'd69 || Db !== 32'd69) begin errors++; $display("FAIL write_read_4: got v=%b %0d/%0d expected v=1 69/69", rsp_valid, Da, Db); end
        WrEn = 1'b1; Aw = 5'd0; Dw = 32'd69;
        cycle();
        checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL write_zero_err: got %b expected 0", wr_err); end
        WrEn = 1'b0; rd_valid = 1'b1; Aa = 5'd0; Ab = 5'd0;
        cycle();
        rd_valid = 1'b0;
        checks++; if (Da !== 32'd0 || Db !== 32'd0 || wr_err !== 1'b0) begin errors++; $display("FAIL write_read_0: got %0d/%0d err=%b expected 0/0 err=0", Da, Db, wr_err); end
    endtask

    task automatic test_bypass();
        WrEn = 1'b1; Aw = 5'd25; Dw = 32'd420;
        rd_valid = 1'b1; Aa = 5'd4; Ab = 5'd25;
        cycle();
        checks++; if (Da !== 32'd69 || Db !== 32'd420) begin errors++; $display("FAIL bypass: got %0d/%0d expected 69/420", Da, Db); end
        WrEn = 1'b0; Dw = 32'd42; Aw = 5'd25; Aa = 5'd25; Ab = 5'd25;
        cycle();
        rd_valid = 1'b0;
        checks++; if (Da !== 32'd420 || Db !== 32'd420) begin errors++; $display("FAIL bypass_no_write: got %0d/%0d expected 420/420", Da, Db); end
    endtask

    task automatic test_back_to_back();
        bit held_ok;
        rd_valid = 1'b0; rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0; rd_valid = 1'b1; Aa = 5'd4; Ab = 5'd4;
        cycle();
        checks++; if (rsp_valid !== 1'b1 || Da !== 32'd69) begin errors++; $display("FAIL bp_capture: got v=%b %0d expected v=1 69", rsp_valid, Da); end
        Aa = 5'd25; Ab = 5'd25;
        held_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (rsp_valid !== 1'b1 || Da !== 32'd69 || obs_rd_ready !== 1'b0) held_ok = 1'b0;
        end
        checks++; if (!held_ok) begin errors++; $display("FAIL bp_hold: got v=%b Da=%0d rd_ready=%b expected v=1 Da=69 rd_ready=0", rsp_valid, Da, obs_rd_ready); end
        rsp_ready = 1'b1;
        cycle();
        checks++; if (obs_rd_ready !== 1'b1 || rsp_valid !== 1'b1 || Da !== 32'd420) begin errors++; $display("FAIL bp_b2b: got rdy=%b v=%b Da=%0d expected rdy=1 v=1 Da=420", obs_rd_ready, rsp_valid, Da); end
        rd_valid = 1'b0;
        cycle();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_retire: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_clear();
        int n;
        bit err_after;
        clear = 1'b1; WrEn = 1'b1; Aw = 5'd9; Dw = 32'd5;
        cycle();
        clear = 1'b0; WrEn = 1'b0;
        checks++; if (wr_err !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL clear_drop: got err=%b busy=%b expected 1/1", wr_err, busy); end
        n = 0; err_after = 1'b0;
        for (int i = 0; i < 40 && busy === 1'b1; i++) begin
            n++;
            cycle();
            if (i == 0) err_after = wr_err;
        end
        checks++; if (n != 32) begin errors++; $display("FAIL clear_busy_len: got %0d expected 32", n); end
        checks++; if (err_after !== 1'b0) begin errors++; $display("FAIL clear_err_pulse: got %b expected 0", err_after); end
        rd_valid = 1'b1; Aa = 5'd4; Ab = 5'd9;
        cycle();
        checks++; if (rsp_valid !== 1'b1 || Da !== 32'd0 || Db !== 32'd0) begin errors++; $display("FAIL clear_read_4_9: got v=%b %0d/%0d expected v=1 0/0", rsp_valid, Da, Db); end
        Aa = 5'd25; Ab = 5'd25;
        cycle();
        rd_valid = 1'b0;
        checks++; if (Da !== 32'd0 || Db !== 32'd0) begin errors++; $display("FAIL clear_read_25: got %0d/%0d expected 0/0", Da, Db); end
        cycle();
    endtask

    task automatic test_reset_mid();
        int n;
        bit held_ok;
        WrEn = 1'b1; Aw = 5'd3; Dw = 32'd77;
        cycle();
        WrEn = 1'b0; rd_valid = 1'b1; Aa = 5'd3; Ab = 5'd0; clear = 1'b1; rsp_ready = 1'b0;
        cycle();
        clear = 1'b0; rd_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || Da !== 32'd77 || busy !== 1'b1) begin errors++; $display("FAIL mid_preclear_read: got v=%b Da=%0d busy=%b expected v=1 77 1", rsp_valid, Da, busy); end
        held_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (rsp_valid !== 1'b1 || Da !== 32'd77) held_ok = 1'b0;
        end
        checks++; if (!held_ok) begin errors++; $display("FAIL mid_pending_hold: got v=%b Da=%0d expected v=1 77", rsp_valid, Da); end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (rsp_valid !== 1'b0 || Da !== 32'd0 || busy !== 1'b1) begin errors++; $display("FAIL mid_reset: got v=%b Da=%0d busy=%b expected 0 0 1", rsp_valid, Da, busy); end
        rsp_ready = 1'b1;
        repeat (2) cycle();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && busy === 1'b1; i++) begin
            n++;
            cycle();
        end
        checks++; if (n != 32) begin errors++; $display("FAIL mid_busy_len: got %0d expected 32", n); end
    endtask

    task automatic test_random();
        int bad_rdy, bad_busy, bad_rsp, bad_err;
        bad_rdy = 0; bad_busy = 0; bad_rsp = 0; bad_err = 0;
        for (int i = 0; i < 500; i++) begin
            clear     = ($urandom_range(0, 59) == 0);
            WrEn      = ($urandom_range(0, 1) == 1);
            Aw        = AW'($urandom_range(0, D - 1));
            Dw        = $urandom;
            rd_valid  = ($urandom_range(0, 9) < 6);
            Aa        = ($urandom_range(0, 3) == 0) ? Aw : AW'($urandom_range(0, D - 1));
            Ab        = ($urandom_range(0, 5) == 0) ? Aa : AW'($urandom_range(0, D - 1));
            rsp_ready = ($urandom_range(0, 9) < 7);
            cycle();
            checks++; if (obs_rd_ready !== exp_rd_ready) begin errors++; bad_rdy++; if (bad_rdy < 4) $display("FAIL rand_rd_ready cyc %0d: got %b expected %b", i, obs_rd_ready, exp_rd_ready); end
            checks++; if (busy !== (m_clear_left != 0)) begin errors++; bad_busy++; if (bad_busy < 4) $display("FAIL rand_busy cyc %0d: got %b expected %b", i, busy, (m_clear_left != 0)); end
            checks++; if (rsp_valid !== m_rsp_valid || Da !== m_da || Db !== m_db) begin errors++; bad_rsp++; if (bad_rsp < 4) $display("FAIL rand_rsp cyc %0d: got v=%b %h/%h expected v=%b %h/%h", i, rsp_valid, Da, Db, m_rsp_valid, m_da, m_db); end
            checks++; if (wr_err !== m_wr_err) begin errors++; bad_err++; if (bad_err < 4) $display("FAIL rand_wr_err cyc %0d: got %b expected %b", i, wr_err, m_wr_err); end
        end
        clear = 1'b0; WrEn = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_read();
        test_bypass();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
